// File: rtl/circ_seq_pkg.sv
// circ_seq_pkg: shared FSM state type and default sizing for circ_seq_queue
package circ_seq_pkg;
  typedef enum logic [1:0] {FILL, IDLE, SEQ} state_e;
  localparam int DATA_W_DEF  = 16;
  localparam int NCH_DEF     = 2;
  localparam int DEPTH_DEF   = 1536;
  localparam int SEQ_LEN_DEF = 1021;
endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: DEPTH x W storage, one write port, one registered read port
// ports: clk/rst (rst clears only the read register), we_i/waddr_i/wdata_i write,
//        re_i/raddr_i read request, rdata_o holds its value while re_i is low
module dual_port_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  // read-first: a read and a write to the same address return the old word
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (rst) rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/circ_seq_queue.sv
// circ_seq_queue: circular sample store that replays the oldest SEQ_LEN samples after each write once full
// ports: clk, rst (sync, active-high); wrt_smpl/new_smpl write strobe and data;
//        smpl_out/sequencing/seq_done replay stream; full, overrun (sticky lost request)
module circ_seq_queue
  import circ_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NCH     = NCH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int SEQ_LEN = SEQ_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrt_smpl,
  input  logic [NCH*DATA_W-1:0] new_smpl,
  output logic [NCH*DATA_W-1:0] smpl_out,
  output logic                  sequencing,
  output logic                  seq_done,
  output logic                  full,
  output logic                  overrun
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(SEQ_LEN + 1);
  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, old_ptr_q, old_ptr_d, rd_ptr_q, rd_ptr_d, pend_ptr_q, pend_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] rd_cnt_q, rd_cnt_d;
  logic          pend_q, pend_d, ovr_q, ovr_d, seq_q, done_q, req, last_rd;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full       = count_q == CW'(DEPTH);
  assign overrun    = ovr_q;
  assign sequencing = seq_q;
  assign seq_done   = done_q;
  // a write requests a sequence when it leaves the store full, including the filling write
  assign req     = wrt_smpl && count_q >= CW'(DEPTH - 1);
  assign last_rd = state_q == SEQ && rd_cnt_q == SW'(SEQ_LEN - 1);
  always_comb begin
    wr_ptr_d   = wrt_smpl ? inc(wr_ptr_q) : wr_ptr_q;
    count_d    = wrt_smpl && !full ? count_q + 1'b1 : count_q;
    old_ptr_d  = wrt_smpl && full ? inc(old_ptr_q) : old_ptr_q;
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    pend_d     = pend_q;
    pend_ptr_d = pend_ptr_q;
    ovr_d      = ovr_q;
    case (state_q)
      FILL, IDLE: begin
        if (req) begin
          state_d  = SEQ;
          rd_ptr_d = old_ptr_d;
          rd_cnt_d = '0;
        end
      end
      SEQ: begin
        if (last_rd) begin
          // the pending slot frees up here, so a coincident write is queued rather than lost
          if (pend_q) begin
            rd_ptr_d   = pend_ptr_q;
            rd_cnt_d   = '0;
            pend_d     = wrt_smpl;
            pend_ptr_d = old_ptr_d;
          end else if (wrt_smpl) begin
            rd_ptr_d = old_ptr_d;
            rd_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rd_ptr_d = inc(rd_ptr_q);
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (wrt_smpl && pend_q) ovr_d = 1'b1;
          else if (wrt_smpl) begin
            pend_d     = 1'b1;
            pend_ptr_d = old_ptr_d;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      old_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      pend_ptr_q <= '0;
      count_q    <= '0;
      rd_cnt_q   <= '0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      seq_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      old_ptr_q  <= old_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_ptr_q <= pend_ptr_d;
      count_q    <= count_d;
      rd_cnt_q   <= rd_cnt_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      seq_q      <= state_q == SEQ;
      done_q     <= last_rd;
    end
  end
  dual_port_ram #(.W(NCH * DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wrt_smpl && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (new_smpl),
    .re_i    (state_q == SEQ),
    .raddr_i (rd_ptr_q),
    .rdata_o (smpl_out)
  );
endmodule

// File: tb/tb_circ_seq_queue.sv
// tb_circ_seq_queue: table, directed and random checks of circ_seq_queue against a timeline model
module tb_circ_seq_queue;
  localparam int D = 8;
  localparam int L = 5;
  logic        clk = 1'b0;
  logic        rst, wrt_smpl, sequencing, seq_done, full, overrun;
  logic [31:0] new_smpl, smpl_out;
  int          total = 0, bad = 0, cyc = 0, nwr = 0;
  logic [31:0] mem_m [D];
  logic        m_seq, m_done, m_full, m_ovr;
  logic [31:0] m_out;
  typedef struct {int start; int sa;} req_t;
  req_t        reqs[$];
  logic [15:0] cap[$];
  typedef struct {logic r; logic w; logic [15:0] d0; logic e_seq; logic e_done; logic e_full; logic [15:0] e_ch0;} vec_t;
  vec_t        tbl[22];

  circ_seq_queue #(.DATA_W(16), .NCH(2), .DEPTH(D), .SEQ_LEN(L)) dut (
    .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl), .smpl_out(smpl_out),
    .sequencing(sequencing), .seq_done(seq_done), .full(full), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: each accepted request owns SEQ_LEN consecutive read cycles starting
  // no earlier than the cycle after it and no earlier than the end of the previous one.
  task automatic model_step(input logic r, input logic w, input logic [31:0] d);
    int  i;
    bit  pend;
    if (r) begin
      nwr = 0; reqs.delete(); m_seq = 0; m_done = 0; m_out = '0; m_ovr = 0; m_full = 0;
      return;
    end
    m_seq = 0; m_done = 0;
    if (reqs.size() > 0 && reqs[0].start <= cyc) begin
      i = cyc - reqs[0].start;
      m_out = mem_m[(reqs[0].sa + i) % D];
      m_seq = 1;
      m_done = (i == L - 1);
      if (m_done) void'(reqs.pop_front());
    end
    if (w) begin
      mem_m[nwr % D] = d;
      nwr++;
      if (nwr >= D) begin
        pend = 0;
        foreach (reqs[k]) if (reqs[k].start > cyc + 1) pend = 1;
        if (pend) m_ovr = 1;
        else if (reqs.size() == 0) reqs.push_back('{cyc + 1, nwr % D});
        else reqs.push_back('{(reqs[$].start + L > cyc + 1) ? reqs[$].start + L : cyc + 1, nwr % D});
      end
    end
    m_full = nwr >= D;
  endtask

  task automatic tick(input logic r, input logic w, input logic [15:0] d0);
    rst = r;
    wrt_smpl = w;
    new_smpl = {d0 + 16'h8000, d0};
    model_step(r, w, new_smpl);
    @(posedge clk);
    #1;
    cyc++;
    if (sequencing) cap.push_back(smpl_out[15:0]);
    chk("sequencing", 32'(sequencing), 32'(m_seq));
    chk("seq_done", 32'(seq_done), 32'(m_done));
    chk("full", 32'(full), 32'(m_full));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("smpl_out", smpl_out, m_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0);
  endtask

  function automatic vec_t mk(input logic r, input logic w, input int d0, input logic s,
                              input logic dn, input logic f, input int e);
    return '{r, w, 16'(d0), s, dn, f, 16'(e)};
  endfunction

  initial begin
    logic [31:0] e_out;
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) tbl[k] = mk(0, 1, k, 0, 0, 0, 0);
    tbl[8] = mk(0, 1, 8, 0, 0, 1, 0);
    for (int k = 9; k <= 13; k++) tbl[k] = mk(0, 0, 0, 1, k == 13, 1, k - 8);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 5);
    tbl[15] = mk(0, 1, 9, 0, 0, 1, 5);
    for (int k = 16; k <= 20; k++) tbl[k] = mk(0, 0, 0, 1, k == 20, 1, k - 14);
    tbl[21] = mk(0, 0, 0, 0, 0, 1, 6);
    for (int k = 0; k < 22; k++) begin
      tick(tbl[k].r, tbl[k].w, tbl[k].d0);
      e_out = tbl[k].e_ch0 == 0 ? 32'h0 : {tbl[k].e_ch0 + 16'h8000, tbl[k].e_ch0};
      chk("tbl_seq", 32'(sequencing), 32'(tbl[k].e_seq));
      chk("tbl_done", 32'(seq_done), 32'(tbl[k].e_done));
      chk("tbl_full", 32'(full), 32'(tbl[k].e_full));
      chk("tbl_out", smpl_out, e_out);
    end
    for (int v = 10; v <= 20; v++) begin
      cap.delete();
      tick(1'b0, 1'b1, 16'(v));
      idle(9);
    end
    chk("wrap_len", cap.size(), L);
    for (int i = 0; i < L && i < cap.size(); i++) chk("wrap_val", 32'(cap[i]), 32'(13 + i));
    cap.delete();
    tick(1'b0, 1'b1, 16'd21);
    tick(1'b0, 1'b1, 16'd22);
    idle(12);
    chk("b2b_len", cap.size(), 2 * L);
    for (int i = 0; i < 2 * L && i < cap.size(); i++)
      chk("b2b_val", 32'(cap[i]), 32'(i < L ? 14 + i : 10 + i));
    chk("b2b_ovr", 32'(overrun), 32'h0);
    tick(1'b0, 1'b1, 16'd23);
    tick(1'b0, 1'b1, 16'd24);
    tick(1'b0, 1'b1, 16'd25);
    idle(20);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    tick(1'b0, 1'b1, 16'd26);
    idle(3);
    tick(1'b1, 1'b0, 16'h0);
    chk("rst_seq", 32'(sequencing), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    idle(4);
    cap.delete();
    for (int k = 1; k <= D; k++) tick(1'b0, 1'b1, 16'(100 + k));
    idle(7);
    chk("refill_len", cap.size(), L);
    for (int i = 0; i < L && i < cap.size(); i++) chk("refill_val", 32'(cap[i]), 32'(101 + i));
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) tick(1'b1, 1'b0, 16'h0);
      else tick(1'b0, $urandom_range(0, 3) == 0, 16'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/circ_seq_queue.md
CIRC_SEQ_QUEUE -- requirements
Module: circ_seq_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width per channel.
REQ-002 SHALL have parameter NCH, default 2: independent channels written and read in lockstep.
REQ-003 SHALL have parameter DEPTH, default 1536: samples stored per channel.
REQ-004 SHALL have parameter SEQ_LEN, default 1021: samples emitted per sequence, 1 <= SEQ_LEN <= DEPTH.
REQ-005 SHALL have port clk, input, 1: the only clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port wrt_smpl, input, 1: one-cycle strobe, write new_smpl.
REQ-008 SHALL have port new_smpl, input, NCH*DATA_W: channel k at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port smpl_out, output, NCH*DATA_W: sequenced sample, same packing as new_smpl.
REQ-010 SHALL have port sequencing, output, 1: smpl_out valid this cycle.
REQ-011 SHALL have port seq_done, output, 1: one-cycle pulse coincident with the last valid sample of a sequence.
REQ-012 SHALL have port full, output, 1: DEPTH samples stored.
REQ-013 SHALL have port overrun, output, 1: sticky flag, sequence request lost.

Function
REQ-014 SHALL write new_smpl at wr_ptr in the cycle wrt_smpl is high; wr_ptr SHALL advance by 1 and wrap DEPTH-1 -> 0.
REQ-015 SHALL keep a count, width $clog2(DEPTH+1), that increments per write and saturates at DEPTH; full = (count == DEPTH).
REQ-016 SHALL hold old_ptr at 0 while not full; on a write while full, the oldest sample is overwritten and old_ptr SHALL advance by 1 with wrap.
REQ-017 SHALL request a sequence on any write that leaves full=1, including the write that first sets it.
REQ-018 SHALL implement states FILL (count < DEPTH), IDLE (full, no sequence), SEQ (emitting).
REQ-019 SHALL make these transitions: FILL -> SEQ on the filling write; IDLE -> SEQ on a write; SEQ -> IDLE after the last read if nothing is pending; SEQ -> SEQ if a request is pending.
REQ-020 SHALL, for a request raised by a write at cycle T, issue read addresses old_ptr(post-write), +1, ... (mod DEPTH) in cycles T+1 .. T+SEQ_LEN.
REQ-021 SHALL have one-cycle read latency, so smpl_out is valid and sequencing=1 in cycles T+2 .. T+SEQ_LEN+1, oldest sample first.
REQ-022 SHALL hold smpl_out at its last value when sequencing=0.
REQ-023 SHALL store a write arriving during SEQ immediately, since the write port is independent; that write sets a one-deep pending request.
REQ-024 SHALL capture the start address of a pending sequence at the moment of the request, not when it starts.
REQ-025 SHALL start a pending sequence's first read in the cycle after the previous sequence's last read, with no gap in sequencing.
REQ-026 SHALL set overrun and discard the new request when a write arrives while a request is already pending; the write data is still stored.
REQ-027 SHALL, on simultaneous wrt_smpl and the last read of a sequence, treat the write as a new pending request (no overrun).

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set wr_ptr=0, old_ptr=0, count=0, state=FILL, pending=0, overrun=0, full=0, sequencing=0, seq_done=0, smpl_out=0.
REQ-029 SHALL abort an in-flight sequence on reset with no further sequencing pulses; memory contents are not cleared.
REQ-030 SHALL have reset take priority over a wrt_smpl in the same cycle.

Structure
REQ-031 SHALL place the state enum (FILL, IDLE, SEQ) and default parameter constants in package circ_seq_pkg.
REQ-032 SHALL instantiate one sub-module, dual_port_ram (DEPTH x NCH*DATA_W, 1 write port, 1 read port, synchronous read), for storage.
REQ-033 SHALL keep pointer, counter and FSM logic in circ_seq_queue, with no other sub-modules.

Verification (DEPTH=8, SEQ_LEN=5, NCH=2, DATA_W=16)
REQ-034 SHALL cover: write 1..7 -> full=0, sequencing never high; write 8 -> full=1, smpl_out ch0 = 1,2,3,4,5 in cycles T+2..T+6, seq_done at T+6.
REQ-035 SHALL cover: after the above, write 9 when idle -> sequence 2,3,4,5,6 (oldest overwritten, old_ptr wraps correctly).
REQ-036 SHALL cover: writes 9..20 spaced 10 cycles apart -> last sequence 13,14,15,16,17, with pointers wrapped at least once.
REQ-037 SHALL cover: one write during SEQ -> back-to-back sequences with no sequencing gap, overrun=0; two writes during SEQ -> overrun=1 and stays 1 until rst.
REQ-038 SHALL cover: rst asserted mid-sequence -> next cycle sequencing=0, full=0, count=0; a refill of 8 writes reproduces REQ-034 timing.
REQ-039 SHALL cover: ch1 = ch0 + 0x8000 on every write -> smpl_out ch1 tracks ch1 data independently in every scenario.
